// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage placed after the ALU.
// ALU-only ops are passed through to write-back one cycle after they are
// accepted. Loads and stores go to an internal word-organised data memory
// with MEM_LAT extra wait cycles, and upstream is stalled for that time.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          an op is present on the inputs (sampled while stall=0)
//   alu_result        ALU result; byte address for memory ops
//   store_data        store data (Rt)
//   dest_reg          write-back register index
//   mem_read/write    load / store (both set = store)
//   reg_write         op writes a register
//   size              00 byte, 01 half, 1x word
//   load_signed       sign-extend byte/half loads
//   stall             upstream must hold its inputs
//   wb_valid          one-cycle write-back pulse
//   wb_we/addr/data   register-file write bundle
//   misalign          with wb_valid: the memory op was misaligned
module mem_stage #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [1:0]  size,
  input  logic        load_signed,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        misalign
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OA_W  = ADDR_W + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // Everything the stage needs to remember about one memory op.
  typedef struct packed {
    logic [OA_W-1:0] addr;
    logic [31:0]     data;
    logic [4:0]      dest;
    logic            is_load;
    logic            is_store;
    logic            rw;
    logic [1:0]      size;
    logic            sgn;
    logic            mis;
  } op_t;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  op_t              op_q, op_nxt;
  op_t              in_op_c, cur_c;

  logic             wb_valid_nxt, wb_we_nxt, mis_nxt;
  logic [4:0]       wb_addr_nxt;
  logic [31:0]      wb_data_nxt;
  logic             enter_resp_c;
  logic             mem_we_c;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx_c;
  logic [1:0]        lane_c;
  logic [31:0]       rd_word_c, wr_word_c, load_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;

  // Address bits above the word index are intentionally ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^alu_result[31:OA_W];

  // Decode the incoming op, including the alignment check.
  always_comb begin
    in_op_c          = '0;
    in_op_c.addr     = alu_result[OA_W-1:0];
    in_op_c.data     = store_data;
    in_op_c.dest     = dest_reg;
    in_op_c.is_store = mem_write;
    in_op_c.is_load  = mem_read & ~mem_write;
    in_op_c.rw       = reg_write;
    in_op_c.size     = size;
    in_op_c.sgn      = load_signed;
    in_op_c.mis      = ((size == 2'b01) && alu_result[0]) ||
                       (size[1] && (alu_result[1:0] != 2'b00));
  end

  // In IDLE the op comes straight from the inputs (needed when MEM_LAT=0).
  assign cur_c     = (state == IDLE) ? in_op_c : op_q;
  assign idx_c     = cur_c.addr[OA_W-1:2];
  assign lane_c    = cur_c.addr[1:0];
  assign rd_word_c = mem[idx_c];

  // Load lane extraction and extension.
  always_comb begin
    byte_c = 8'(rd_word_c >> {lane_c, 3'b000});
    half_c = lane_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    case (cur_c.size)
      2'b00:   load_c = cur_c.sgn ? {{24{byte_c[7]}}, byte_c} : {24'd0, byte_c};
      2'b01:   load_c = cur_c.sgn ? {{16{half_c[15]}}, half_c} : {16'd0, half_c};
      default: load_c = rd_word_c;
    endcase
  end

  // Store merge: only the addressed lanes change.
  always_comb begin
    wr_word_c = rd_word_c;
    case (cur_c.size)
      2'b00:   wr_word_c[{lane_c, 3'b000} +: 8] = cur_c.data[7:0];
      2'b01: begin
        if (lane_c[1]) wr_word_c[31:16] = cur_c.data[15:0];
        else           wr_word_c[15:0]  = cur_c.data[15:0];
      end
      default: wr_word_c = cur_c.data;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    op_nxt       = op_q;
    wb_valid_nxt = 1'b0;
    wb_we_nxt    = 1'b0;
    wb_addr_nxt  = wb_addr;
    wb_data_nxt  = wb_data;
    mis_nxt      = 1'b0;
    enter_resp_c = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (mem_read || mem_write) begin
            op_nxt = in_op_c;
            if (MEM_LAT == 0) begin
              state_nxt    = RESP;
              enter_resp_c = 1'b1;
            end else begin
              state_nxt = ACCESS;
              cnt_nxt   = CNT_W'(MEM_LAT);
            end
          end else begin
            wb_valid_nxt = 1'b1;
            wb_we_nxt    = reg_write && (dest_reg != 5'd0);
            wb_addr_nxt  = dest_reg;
            wb_data_nxt  = alu_result;
          end
        end
      end
      ACCESS: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt    = RESP;
          cnt_nxt      = '0;
          enter_resp_c = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // The write-back bundle is registered on the edge into RESP so that it is
    // visible during the RESP cycle (MEM_LAT+1 cycles after acceptance).
    if (enter_resp_c) begin
      wb_valid_nxt = 1'b1;
      wb_addr_nxt  = cur_c.dest;
      mis_nxt      = cur_c.mis;
      if (cur_c.is_load && !cur_c.mis) begin
        wb_data_nxt = load_c;
        wb_we_nxt   = cur_c.rw && (cur_c.dest != 5'd0);
      end
    end
  end

  // Memory is written together with the response; never while in reset.
  assign mem_we_c = enter_resp_c && cur_c.is_store && !cur_c.mis && rst_n;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      stall    <= 1'b0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      op_q     <= op_nxt;
      stall    <= (state_nxt != IDLE);
      wb_valid <= wb_valid_nxt;
      wb_we    <= wb_we_nxt;
      wb_addr  <= wb_addr_nxt;
      wb_data  <= wb_data_nxt;
      misalign <= mis_nxt;
    end
  end

  // Data memory: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= wr_word_c;
  end

endmodule
